// File: rtl/apb_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_fifo_pkg
// Description : Register offsets and bit positions for apb_fifo_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_fifo_pkg;

    // Byte offsets; only bits [4:2] take part in decode
    localparam logic [4:0] ADDR_DATA   = 5'h00;
    localparam logic [4:0] ADDR_STATUS = 5'h04;
    localparam logic [4:0] ADDR_CTRL   = 5'h08;
    localparam logic [4:0] ADDR_LEVEL  = 5'h0C;
    localparam logic [4:0] ADDR_THRESH = 5'h10;

    localparam int unsigned c_ST_TX_EMPTY = 0;
    localparam int unsigned c_ST_TX_FULL  = 1;
    localparam int unsigned c_ST_RX_EMPTY = 2;
    localparam int unsigned c_ST_RX_FULL  = 3;
    localparam int unsigned c_ST_TX_OVF   = 4;
    localparam int unsigned c_ST_RX_OVF   = 5;
    localparam int unsigned c_ST_RX_UDF   = 6;

    localparam int unsigned c_CTRL_IE_TX    = 0;
    localparam int unsigned c_CTRL_IE_RX    = 1;
    localparam int unsigned c_CTRL_IE_ERR   = 2;
    localparam int unsigned c_CTRL_TX_FLUSH = 3;
    localparam int unsigned c_CTRL_RX_FLUSH = 4;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Show-ahead synchronous FIFO with flush and overflow pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_ovf
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A pop frees a slot, so a push into a full FIFO is accepted alongside it
    assign w_pop_ok  = i_pop & ~w_empty & ~i_flush;
    assign w_push_ok = i_push & (~w_full | w_pop_ok) & ~i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok & ~rst) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_ovf   = i_push & w_full & ~w_pop_ok & ~i_flush;

endmodule
`default_nettype wire

// File: rtl/apb_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_fifo_bridge
// Description : APB slave with TX/RX FIFOs, status/ctrl/level/threshold regs.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_fifo_bridge
    import apb_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_empty,
    input  logic              tx_pop,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_push,
    output logic              rx_full,
    output logic              irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              w_acc;
    logic [2:0]        w_sel;
    logic [31:0]       w_wdata32;
    logic [31:0]       w_rd32;
    logic              w_tx_push, w_rx_pop;
    logic              w_stat_wr, w_ctrl_wr, w_thr_wr;
    logic              w_tx_flush, w_rx_flush;
    logic [CNT_W-1:0]  w_tx_count, w_rx_count;
    logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic              w_tx_ovf, w_rx_ovf, w_rx_udf;
    logic [DATA_W-1:0] w_rx_head;
    logic [2:0]        w_sticky_set, w_sticky_clr;
    logic              w_irq_next;
    logic              w_unused;

    logic [2:0]        r_sticky;   // {rx_udf, rx_ovf, tx_ovf}
    logic [2:0]        r_ie;       // {ie_err, ie_rx, ie_tx}
    logic [CNT_W-1:0]  r_tx_thr, r_rx_thr;
    logic              r_irq;

    assign w_acc     = PSELx & PENABLE;
    assign w_sel     = PADDR[4:2];
    assign w_wdata32 = 32'(PWDATA);

    assign w_tx_push  = w_acc &  PWRITE & (w_sel == ADDR_DATA[4:2]);
    assign w_rx_pop   = w_acc & ~PWRITE & (w_sel == ADDR_DATA[4:2]);
    assign w_stat_wr  = w_acc &  PWRITE & (w_sel == ADDR_STATUS[4:2]);
    assign w_ctrl_wr  = w_acc &  PWRITE & (w_sel == ADDR_CTRL[4:2]);
    assign w_thr_wr   = w_acc &  PWRITE & (w_sel == ADDR_THRESH[4:2]);
    assign w_tx_flush = w_ctrl_wr & w_wdata32[c_CTRL_TX_FLUSH];
    assign w_rx_flush = w_ctrl_wr & w_wdata32[c_CTRL_RX_FLUSH];
    // Underflow is judged on the pre-edge level, so a same-cycle rx_push cannot rescue it
    assign w_rx_udf   = w_rx_pop & w_rx_empty;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (PCLK),
        .rst     (PRESET),
        .i_push  (w_tx_push),
        .i_pop   (tx_pop),
        .i_flush (w_tx_flush),
        .i_wdata (PWDATA),
        .o_head  (tx_data),
        .o_count (w_tx_count),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_ovf   (w_tx_ovf)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (PCLK),
        .rst     (PRESET),
        .i_push  (rx_push),
        .i_pop   (w_rx_pop),
        .i_flush (w_rx_flush),
        .i_wdata (rx_data),
        .o_head  (w_rx_head),
        .o_count (w_rx_count),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_ovf   (w_rx_ovf)
    );

    assign w_sticky_set = {w_rx_udf, w_rx_ovf, w_tx_ovf};
    assign w_sticky_clr = w_stat_wr ? w_wdata32[c_ST_RX_UDF:c_ST_TX_OVF] : 3'b000;

    assign w_irq_next = (r_ie[c_CTRL_IE_TX]  & (w_tx_count <= r_tx_thr))
                      | (r_ie[c_CTRL_IE_RX]  & (w_rx_count >= r_rx_thr))
                      | (r_ie[c_CTRL_IE_ERR] & (|r_sticky));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_sticky <= '0;
            r_ie     <= '0;
            r_tx_thr <= '0;
            r_rx_thr <= CNT_W'(DEPTH);
            r_irq    <= 1'b0;
        end else begin
            r_sticky <= (r_sticky & ~w_sticky_clr) | w_sticky_set;
            r_irq    <= w_irq_next;
            if (w_ctrl_wr) r_ie <= w_wdata32[c_CTRL_IE_ERR:c_CTRL_IE_TX];
            if (w_thr_wr) begin
                r_tx_thr <= w_wdata32[CNT_W-1:0];
                r_rx_thr <= w_wdata32[CNT_W+15:16];
            end
        end
    end

    always_comb begin
        w_rd32 = '0;
        if (w_acc & ~PWRITE) begin
            case (w_sel)
                ADDR_DATA[4:2]: begin
                    if (!w_rx_empty) w_rd32[DATA_W-1:0] = w_rx_head;
                end
                ADDR_STATUS[4:2]: begin
                    w_rd32[c_ST_TX_EMPTY] = w_tx_empty;
                    w_rd32[c_ST_TX_FULL]  = w_tx_full;
                    w_rd32[c_ST_RX_EMPTY] = w_rx_empty;
                    w_rd32[c_ST_RX_FULL]  = w_rx_full;
                    w_rd32[c_ST_RX_UDF:c_ST_TX_OVF] = r_sticky;
                end
                ADDR_CTRL[4:2]:   w_rd32[2:0] = r_ie;
                ADDR_LEVEL[4:2]: begin
                    w_rd32[CNT_W-1:0]     = w_tx_count;
                    w_rd32[CNT_W+15:16]   = w_rx_count;
                end
                ADDR_THRESH[4:2]: begin
                    w_rd32[CNT_W-1:0]     = r_tx_thr;
                    w_rd32[CNT_W+15:16]   = r_rx_thr;
                end
                default: w_rd32 = '0;
            endcase
        end
    end

    assign PRDATA   = w_rd32[DATA_W-1:0];
    assign PREADY   = 1'b1;
    assign PSLVERR  = w_acc & (w_tx_ovf | w_rx_udf);
    assign tx_empty = w_tx_empty;
    assign rx_full  = w_rx_full;
    assign irq      = r_irq;

    assign w_unused = &{1'b0, PADDR[ADDR_W-1:5], PADDR[1:0], w_wdata32, w_rd32};

endmodule
`default_nettype wire
